// File: rtl/fp_req_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : fp_req_master_if
//  Description : Bus bundle for fp_req_master. Groups the request and
//                response handshakes, the arithmetic-slave drive/return
//                signals and the busy flag. The master modport is the view
//                taken by fp_req_master; the slave modport is the
//                environment's view (request source, response sink and
//                arithmetic slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface fp_req_master_if #(
    parameter int N = 32
) ();
    // Request channel
    logic         req_valid;
    logic         req_ready;
    logic [N-1:0] req_a;
    logic [N-1:0] req_b;
    logic [1:0]   req_op;
    // Response channel
    logic         resp_valid;
    logic         resp_ready;
    logic [N-1:0] resp_c;
    logic [1:0]   resp_op;
    // Arithmetic slave
    logic [N-1:0] s_a;
    logic [N-1:0] s_b;
    logic [1:0]   s_opcode;
    logic         s_start;
    logic [N-1:0] s_c;
    // Status
    logic         busy;

    modport master (
        input  req_valid, req_a, req_b, req_op, resp_ready, s_c,
        output req_ready, resp_valid, resp_c, resp_op,
               s_a, s_b, s_opcode, s_start, busy
    );

    modport slave (
        output req_valid, req_a, req_b, req_op, resp_ready, s_c,
        input  req_ready, resp_valid, resp_c, resp_op,
               s_a, s_b, s_opcode, s_start, busy
    );
endinterface
`default_nettype wire

// File: rtl/fp_req_master.sv
`default_nettype none
// ============================================================================
//  Module      : fp_req_master
//  Description : Queues fixed-point operation requests in a DEPTH-entry FIFO
//                and sequences them one at a time through a fixed-latency
//                arithmetic slave, returning results in request order on a
//                valid/ready response channel.
//                Optional feature macro: FP_REQ_MASTER_NEGZERO_EN -- when
//                defined, a negative-zero slave result is returned as +0.
//  Revision    : 1.0  initial release
// ============================================================================
module fp_req_master #(
    parameter int N     = 32,   // word width, sign-magnitude, bit N-1 = sign
    parameter int Q     = 15,   // fractional bits
    parameter int LAT   = 2,    // slave latency, 1..15
    parameter int DEPTH = 4     // request FIFO entries, power of two >= 2
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    fp_req_master_if.master    bus
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_DW = 2 * N + 2;

    // Parameter sanity checks, evaluated at elaboration.
    if ((LAT < 1) || (LAT > 15)) begin : g_chk_lat
        $error("fp_req_master: LAT must be in 1..15");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("fp_req_master: DEPTH must be a power of two >= 2");
    end
    if ((Q < 0) || (Q > N - 2)) begin : g_chk_q
        $error("fp_req_master: Q must leave room for the sign bit");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [c_DW-1:0]   r_mem [DEPTH];
    logic [c_AW:0]     r_wr_ptr;
    logic [c_AW:0]     r_rd_ptr;
    logic [3:0]        r_cnt;

    logic [N-1:0]      r_s_a;
    logic [N-1:0]      r_s_b;
    logic [1:0]        r_s_opcode;
    logic [N-1:0]      r_resp_c;
    logic [1:0]        r_resp_op;
    logic              r_resp_valid;

    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_capture;
    logic              w_resp_hs;
    logic [c_DW-1:0]   w_head;
    logic [N-1:0]      w_c_cap;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    // Ready depends only on fullness, so a pop on a full FIFO never frees
    // the slot for a push in the same cycle.
    assign bus.req_ready = rst_n && !w_full;
    assign w_push    = bus.req_valid && bus.req_ready;
    assign w_resp_hs = r_resp_valid && bus.resp_ready;
    assign w_head    = r_mem[r_rd_ptr[c_AW-1:0]];

`ifdef FP_REQ_MASTER_NEGZERO_EN
    localparam logic [N-1:0] c_NEG_ZERO = {1'b1, {(N-1){1'b0}}};
    assign w_c_cap = (bus.s_c == c_NEG_ZERO) ? '0 : bus.s_c;
`else
    assign w_c_cap = bus.s_c;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic plus FIFO pop and result-capture strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_resp_hs) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_ISSUE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= {bus.req_a, bus.req_b, bus.req_op};
    end

    // FIFO pointers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);
        end
    end

    // Latency counter: loaded during the start cycle, counts down in WAIT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else if (r_state == ST_ISSUE) begin
            r_cnt <= 4'(LAT);
        end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Operand registers toward the slave and the held response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s_a        <= '0;
            r_s_b        <= '0;
            r_s_opcode   <= '0;
            r_resp_c     <= '0;
            r_resp_op    <= '0;
            r_resp_valid <= 1'b0;
        end else begin
            if (w_pop) {r_s_a, r_s_b, r_s_opcode} <= w_head;
            if (w_capture) begin
                r_resp_c     <= w_c_cap;
                r_resp_op    <= r_s_opcode;
                r_resp_valid <= 1'b1;
            end else if (w_resp_hs) begin
                r_resp_valid <= 1'b0;
            end
        end
    end

    assign bus.s_a        = r_s_a;
    assign bus.s_b        = r_s_b;
    assign bus.s_opcode   = r_s_opcode;
    assign bus.s_start    = (r_state == ST_ISSUE);
    assign bus.resp_c     = r_resp_c;
    assign bus.resp_op    = r_resp_op;
    assign bus.resp_valid = r_resp_valid;
    assign bus.busy       = !w_empty || (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fp_req_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_req_master
//  Description : Self-checking bench for fp_req_master. A behavioural slave
//                returns a result only in the cycle the master should sample
//                it (random data otherwise); a request-order scoreboard
//                predicts every response.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fp_req_master;
    localparam int N     = 32;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fp_req_master_if #(.N(N)) bus_if ();

    fp_req_master #(.N(N), .Q(15), .LAT(LAT), .DEPTH(DEPTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    typedef struct packed { logic [N-1:0] a; logic [N-1:0] b; logic [1:0] op; } req_t;
    typedef struct { logic [N-1:0] c; logic [1:0] op; int cyc; } obs_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   start_cnt = 0;
    int   refused = 0;
    int   k = 0;
    req_t exp_q[$];
    req_t iss_q[$];
    obs_t obs_q[$];
    int   acc_q[$];

    // Slave arithmetic: sum plus opcode; opcode 3 yields negative zero.
    function automatic logic [N-1:0] slave_f(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic [1:0] op);
        if (op == 2'd3) return {1'b1, {(N-1){1'b0}}};
        return a + b + N'(op);
    endfunction

    // What the master must hand back for a request.
    function automatic logic [N-1:0] model_resp(input req_t r);
        logic [N-1:0] c;
        c = slave_f(r.a, r.b, r.op);
`ifdef FP_REQ_MASTER_NEGZERO_EN
        if (c == {1'b1, {(N-1){1'b0}}}) c = '0;
`endif
        return c;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Slave: k counts cycles since the start pulse; result valid only at k == LAT.
    always @(posedge clk) begin
        if (!rst_n)                    k <= 0;
        else if (bus_if.s_start)       k <= 1;
        else if (k != 0 && k < LAT)    k <= k + 1;
        else                           k <= 0;
    end
    always @(negedge clk) begin
        if (k == LAT) bus_if.s_c = slave_f(bus_if.s_a, bus_if.s_b, bus_if.s_opcode);
        else          bus_if.s_c = N'($urandom);
    end

    // Record every start pulse and the operands presented with it.
    always @(negedge clk) begin
        if (bus_if.s_start === 1'b1) begin
            start_cnt <= start_cnt + 1;
            iss_q.push_back('{bus_if.s_a, bus_if.s_b, bus_if.s_opcode});
        end
    end

    task automatic clear_sb;
        exp_q.delete(); iss_q.delete(); obs_q.delete(); acc_q.delete();
        refused = 0;
    endtask

    // Present one request until accepted or the budget runs out.
    task automatic send_req(input req_t r, input int budget, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < budget && !ok; t++) begin
            @(negedge clk);
            bus_if.req_valid = 1'b1;
            bus_if.req_a = r.a; bus_if.req_b = r.b; bus_if.req_op = r.op;
            if (bus_if.req_ready === 1'b1) begin
                acc_q.push_back(cyc);
                exp_q.push_back(r);
                ok = 1'b1;
            end else begin
                refused++;
            end
            @(posedge clk);
        end
    endtask

    task automatic drop_req;
        @(negedge clk);
        bus_if.req_valid = 1'b0;
    endtask

    // Accept up to n responses; rnd_ready randomises resp_ready.
    task automatic collect(input int n, input int budget, input bit rnd_ready, output int got);
        got = 0;
        for (int t = 0; t < budget && got < n; t++) begin
            @(negedge clk);
            bus_if.resp_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (bus_if.resp_valid === 1'b1 && bus_if.resp_ready) begin
                obs_q.push_back('{bus_if.resp_c, bus_if.resp_op, cyc});
                got++;
            end
            @(posedge clk);
        end
    endtask

    // One isolated request from idle; lat = cycles from request edge to resp_valid.
    task automatic run_one(input req_t r, output int got, output int lat, output int pulses);
        bit ok;
        int s0;
        clear_sb();
        s0 = start_cnt;
        fork
            begin send_req(r, 50, ok); drop_req(); end
            collect(1, 50, 1'b0, got);
        join
        repeat (LAT + 4) @(negedge clk);
        pulses = start_cnt - s0;
        // acc_q holds the cycle before the accepting edge, obs_q the cycle
        // in which resp_valid was first seen.
        lat = (obs_q.size() > 0 && acc_q.size() > 0) ? obs_q[0].cyc - (acc_q[0] + 1) : -1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus_if.req_valid = 1'b0; bus_if.resp_ready = 1'b0;
        bus_if.req_a = '0; bus_if.req_b = '0; bus_if.req_op = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (bus_if.req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready: got %b want 0", bus_if.req_ready); end
        total++; if ({bus_if.resp_valid, bus_if.s_start, bus_if.busy} !== 3'b000) begin
            bad++; $display("FAIL reset_flags: got valid/start/busy=%b want 000", {bus_if.resp_valid, bus_if.s_start, bus_if.busy}); end
        total++; if ({bus_if.resp_c, bus_if.resp_op} !== '0) begin
            bad++; $display("FAIL reset_resp: got c=%h op=%h want 0", bus_if.resp_c, bus_if.resp_op); end
        total++; if ({bus_if.s_a, bus_if.s_b, bus_if.s_opcode} !== '0) begin
            bad++; $display("FAIL reset_slave_drive: got a=%h b=%h op=%h want 0", bus_if.s_a, bus_if.s_b, bus_if.s_opcode); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (bus_if.req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready: got %b want 1", bus_if.req_ready); end
    endtask

    task automatic test_single_op;
        int got, lat, pulses;
        req_t r;
        r = '{a: 32'h0000C000, b: 32'h00012000, op: 2'b00};
        run_one(r, got, lat, pulses);
        total++; if (got !== 1) begin bad++; $display("FAIL single_count: got %0d want 1", got); end
        total++; if (lat !== LAT + 2) begin bad++; $display("FAIL single_latency: got %0d want %0d", lat, LAT + 2); end
        total++; if (pulses !== 1) begin bad++; $display("FAIL single_start_pulses: got %0d want 1", pulses); end
        total++; if (obs_q.size() == 0 || obs_q[0].c !== 32'h0001E000 || obs_q[0].op !== 2'b00) begin
            bad++; $display("FAIL single_resp: got %h/%h want 0001e000/0", obs_q.size() ? obs_q[0].c : 'x, obs_q.size() ? obs_q[0].op : 'x); end
        total++; if (iss_q.size() == 0 || iss_q[0] !== r) begin
            bad++; $display("FAIL single_issue: got %h want %h", iss_q.size() ? iss_q[0] : 'x, r); end
    endtask

    task automatic test_negative_operand;
        int got, lat, pulses;
        req_t r;
        r = '{a: 32'h80008000, b: 32'h00008000, op: 2'b01};
        run_one(r, got, lat, pulses);
        total++; if (iss_q.size() == 0 || iss_q[0] !== r) begin
            bad++; $display("FAIL neg_issue: got %h want %h", iss_q.size() ? iss_q[0] : 'x, r); end
        total++; if (obs_q.size() == 0 || obs_q[0].c !== 32'h80010001 || obs_q[0].op !== 2'b01) begin
            bad++; $display("FAIL neg_resp: got %h/%h want 80010001/1", obs_q.size() ? obs_q[0].c : 'x, obs_q.size() ? obs_q[0].op : 'x); end
    endtask

    task automatic test_negzero;
        int got, lat, pulses;
        req_t r;
        logic [N-1:0] want;
`ifdef FP_REQ_MASTER_NEGZERO_EN
        want = 32'h00000000;
`else
        want = 32'h80000000;
`endif
        r = '{a: 32'h00011111, b: 32'h00022222, op: 2'b11};
        run_one(r, got, lat, pulses);
        total++; if (obs_q.size() == 0 || obs_q[0].c !== want || obs_q[0].op !== 2'b11) begin
            bad++; $display("FAIL negzero_resp: got %h/%h want %h/3", obs_q.size() ? obs_q[0].c : 'x, obs_q.size() ? obs_q[0].op : 'x, want); end
    endtask

    task automatic test_burst;
        int got, early;
        bit ok;
        clear_sb();
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send_req('{a: N'($urandom), b: N'($urandom), op: 2'($urandom_range(0, 2))}, 100, ok);
                end
                drop_req();
            end
            collect(6, 300, 1'b0, got);
        join
        early = 0;
        foreach (acc_q[i]) if (obs_q.size() > 0 && acc_q[i] < obs_q[0].cyc) early++;
        total++; if (got !== 6 || exp_q.size() !== 6) begin bad++; $display("FAIL burst_count: got %0d resp %0d acc want 6", got, exp_q.size()); end
        total++; if (refused == 0) begin bad++; $display("FAIL burst_ready_drop: got %0d refusals want >0", refused); end
        total++; if (early !== DEPTH + 1) begin bad++; $display("FAIL burst_accept_before_resp: got %0d want %0d", early, DEPTH + 1); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (i >= obs_q.size() || i >= exp_q.size() || obs_q[i].c !== model_resp(exp_q[i]) || obs_q[i].op !== exp_q[i].op) begin
                bad++; $display("FAIL burst_order[%0d]: got %h want %h", i, obs_q[i].c, model_resp(exp_q[i])); end
        end
        for (int i = 1; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i].cyc - obs_q[i-1].cyc !== LAT + 2) begin
                bad++; $display("FAIL burst_spacing[%0d]: got %0d want %0d", i, obs_q[i].cyc - obs_q[i-1].cyc, LAT + 2); end
        end
        total++; if (iss_q.size() !== 6 || (iss_q.size() == 6 && iss_q != exp_q)) begin
            bad++; $display("FAIL burst_issue_order: got %0d issues want 6 in order", iss_q.size()); end
    endtask

    task automatic test_backpressure;
        int got, t, s0;
        bit ok, stable;
        logic [N-1:0] c0;
        clear_sb();
        got = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) send_req('{a: N'($urandom), b: N'($urandom), op: 2'($urandom_range(0, 3))}, 100, ok);
                drop_req();
            end
            begin
                @(negedge clk);
                bus_if.resp_ready = 1'b0;
                t = 0;
                while (bus_if.resp_valid !== 1'b1 && t < 50) begin @(negedge clk); t++; end
                total++; if (t >= 50) begin bad++; $display("FAIL bp_first_valid: got timeout want resp_valid"); end
                c0 = bus_if.resp_c;
                s0 = start_cnt;
                stable = 1'b1;
                repeat (10) begin
                    @(negedge clk);
                    if (bus_if.resp_c !== c0 || bus_if.resp_valid !== 1'b1) stable = 1'b0;
                end
                total++; if (exp_q.size() == 0 || c0 !== model_resp(exp_q[0])) begin
                    bad++; $display("FAIL bp_first_value: got %h want %h", c0, model_resp(exp_q[0])); end
                total++; if (!stable) begin bad++; $display("FAIL bp_hold_stable: got changing resp want constant %h", c0); end
                total++; if (start_cnt !== s0) begin bad++; $display("FAIL bp_no_start: got %0d pulses want 0", start_cnt - s0); end
                total++; if (bus_if.req_ready !== 1'b0) begin bad++; $display("FAIL bp_fifo_full: got ready %b want 0", bus_if.req_ready); end
                collect(6, 300, 1'b0, got);
            end
        join
        total++; if (got !== 6) begin bad++; $display("FAIL bp_count: got %0d want 6", got); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (i >= obs_q.size() || i >= exp_q.size() || obs_q[i].c !== model_resp(exp_q[i]) || obs_q[i].op !== exp_q[i].op) begin
                bad++; $display("FAIL bp_order[%0d]: got %h want %h", i, obs_q[i].c, model_resp(exp_q[i])); end
        end
    endtask

    task automatic test_reset_midop;
        bit ok;
        int s0, seen_valid;
        clear_sb();
        s0 = start_cnt;
        @(negedge clk);
        bus_if.resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_req('{a: N'($urandom), b: N'($urandom), op: 2'($urandom_range(0, 3))}, 20, ok);
        // First op is now waiting on the slave with three requests queued.
        @(negedge clk);
        total++; if (start_cnt - s0 !== 1 || bus_if.resp_valid !== 1'b0) begin
            bad++; $display("FAIL midop_in_wait: got %0d starts valid=%b want 1/0", start_cnt - s0, bus_if.resp_valid); end
        rst_n = 1'b0;
        bus_if.req_valid = 1'b0;
        @(negedge clk);
        total++; if ({bus_if.resp_valid, bus_if.busy, bus_if.s_start} !== 3'b000) begin
            bad++; $display("FAIL midop_reset_outputs: got valid/busy/start=%b want 000", {bus_if.resp_valid, bus_if.busy, bus_if.s_start}); end
        rst_n = 1'b1;
        s0 = start_cnt;
        seen_valid = 0;
        repeat (20) begin @(negedge clk); if (bus_if.resp_valid !== 1'b0) seen_valid++; end
        total++; if (seen_valid !== 0 || start_cnt !== s0) begin
            bad++; $display("FAIL midop_no_stale: got %0d valid cycles %0d starts want 0/0", seen_valid, start_cnt - s0); end
        clear_sb();
    endtask

    task automatic test_random;
        localparam int NREQ = 24;
        int got;
        bit ok;
        clear_sb();
        fork
            begin
                for (int i = 0; i < NREQ; i++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        drop_req();
                        repeat ($urandom_range(0, 3)) @(posedge clk);
                    end
                    send_req('{a: N'($urandom), b: N'($urandom), op: 2'($urandom_range(0, 3))}, 200, ok);
                end
                drop_req();
            end
            collect(NREQ, 3000, 1'b1, got);
        join
        total++; if (got !== NREQ || exp_q.size() !== NREQ) begin
            bad++; $display("FAIL rand_count: got %0d resp %0d acc want %0d", got, exp_q.size(), NREQ); end
        for (int i = 0; i < NREQ; i++) begin
            total++;
            if (i >= obs_q.size() || i >= exp_q.size() || obs_q[i].c !== model_resp(exp_q[i]) || obs_q[i].op !== exp_q[i].op) begin
                bad++; $display("FAIL rand_order[%0d]: got %h want %h", i, obs_q[i].c, model_resp(exp_q[i])); end
        end
        total++; if (iss_q.size() !== NREQ || (iss_q.size() == NREQ && iss_q != exp_q)) begin
            bad++; $display("FAIL rand_issue_order: got %0d issues want %0d in order", iss_q.size(), NREQ); end
        @(negedge clk);
        bus_if.resp_ready = 1'b1;
        repeat (5) @(negedge clk);
        total++; if ({bus_if.busy, bus_if.resp_valid} !== 2'b00) begin
            bad++; $display("FAIL rand_drained: got busy/valid=%b want 00", {bus_if.busy, bus_if.resp_valid}); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_op();
        test_negative_operand();
        test_negzero();
        test_burst();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
